// File: rtl/matrix_loader.sv
// matrix_loader: writer side of the matrix-multiply memories.
// Accepts a byte stream over valid/ready and writes A_DEPTH bytes into the
// A RAM, then B_DEPTH bytes into the B RAM, then raises done.
//
// Ports:
//   clock, reset_l      system clock (rising edge), async active-low reset
//   start, abort        begin a load (IDLE/DONE only) / cancel a load
//   in_data, in_valid   stream byte and its valid
//   in_ready            registered; high exactly while loading A or B
//   a_wr_*, b_wr_*      registered RAM write ports, one-cycle strobe
//   busy, done          loading / both matrices resident
//   checksum            16-bit wrap-around sum of accepted bytes
//   loadTicks           saturating count of cycles spent loading
module matrix_loader #(
    parameter int unsigned A_DEPTH = 4096,
    parameter int unsigned A_AW    = 12,
    parameter int unsigned B_DEPTH = 64,
    parameter int unsigned B_AW    = 6,
    parameter int unsigned DW      = 8
) (
    input  logic            clock,
    input  logic            reset_l,
    input  logic            start,
    input  logic            abort,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            a_wr_en,
    output logic [A_AW-1:0] a_wr_addr,
    output logic [DW-1:0]   a_wr_data,
    output logic            b_wr_en,
    output logic [B_AW-1:0] b_wr_addr,
    output logic [DW-1:0]   b_wr_data,
    output logic            busy,
    output logic            done,
    output logic [15:0]     checksum,
    output logic [15:0]     loadTicks
);

    localparam logic [A_AW-1:0] ALast = A_AW'(A_DEPTH - 1);
    localparam logic [B_AW-1:0] BLast = B_AW'(B_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StDone} state_e;

    state_e          state_q, state_d;
    logic [A_AW-1:0] a_cnt_q, a_cnt_d;
    logic [B_AW-1:0] b_cnt_q, b_cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            a_wr_en_q, a_wr_en_d;
    logic [A_AW-1:0] a_wr_addr_q, a_wr_addr_d;
    logic [DW-1:0]   a_wr_data_q, a_wr_data_d;
    logic            b_wr_en_q, b_wr_en_d;
    logic [B_AW-1:0] b_wr_addr_q, b_wr_addr_d;
    logic [DW-1:0]   b_wr_data_q, b_wr_data_d;
    logic [15:0]     checksum_q, checksum_d;
    logic [15:0]     ticks_q, ticks_d;
    logic            xfer;
    logic            loading;

    always_comb begin
        state_d     = state_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;
        a_wr_en_d   = 1'b0;
        a_wr_addr_d = a_wr_addr_q;
        a_wr_data_d = a_wr_data_q;
        b_wr_en_d   = 1'b0;
        b_wr_addr_d = b_wr_addr_q;
        b_wr_data_d = b_wr_data_q;
        checksum_d  = checksum_q;
        ticks_d     = ticks_q;

        loading = (state_q == StLoadA) || (state_q == StLoadB);
        // abort takes priority: no byte is accepted on the abort edge
        xfer    = in_valid && in_ready_q && !abort;

        if (loading && (ticks_q != 16'hFFFF)) begin
            ticks_d = ticks_q + 16'd1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start && !abort) begin
                    state_d    = StLoadA;
                    a_cnt_d    = '0;
                    b_cnt_d    = '0;
                    checksum_d = '0;
                    ticks_d    = '0;
                end
            end
            StLoadA: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (xfer) begin
                    a_wr_en_d   = 1'b1;
                    a_wr_addr_d = a_cnt_q;
                    a_wr_data_d = in_data;
                    a_cnt_d     = a_cnt_q + 1'b1;
                    checksum_d  = checksum_q + 16'(in_data);
                    if (a_cnt_q == ALast) begin
                        state_d = StLoadB;
                    end
                end
            end
            StLoadB: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (xfer) begin
                    b_wr_en_d   = 1'b1;
                    b_wr_addr_d = b_cnt_q;
                    b_wr_data_d = in_data;
                    b_cnt_d     = b_cnt_q + 1'b1;
                    checksum_d  = checksum_q + 16'(in_data);
                    if (b_cnt_q == BLast) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StLoadA) || (state_d == StLoadB);
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= StIdle;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            in_ready_q  <= 1'b0;
            a_wr_en_q   <= 1'b0;
            a_wr_addr_q <= '0;
            a_wr_data_q <= '0;
            b_wr_en_q   <= 1'b0;
            b_wr_addr_q <= '0;
            b_wr_data_q <= '0;
            checksum_q  <= '0;
            ticks_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            in_ready_q  <= in_ready_d;
            a_wr_en_q   <= a_wr_en_d;
            a_wr_addr_q <= a_wr_addr_d;
            a_wr_data_q <= a_wr_data_d;
            b_wr_en_q   <= b_wr_en_d;
            b_wr_addr_q <= b_wr_addr_d;
            b_wr_data_q <= b_wr_data_d;
            checksum_q  <= checksum_d;
            ticks_q     <= ticks_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign a_wr_en   = a_wr_en_q;
    assign a_wr_addr = a_wr_addr_q;
    assign a_wr_data = a_wr_data_q;
    assign b_wr_en   = b_wr_en_q;
    assign b_wr_addr = b_wr_addr_q;
    assign b_wr_data = b_wr_data_q;
    assign busy      = (state_q == StLoadA) || (state_q == StLoadB);
    assign done      = (state_q == StDone);
    assign checksum  = checksum_q;
    assign loadTicks = ticks_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: drives the byte stream, keeps a byte-level model
// (phase, byte count, sum, tick count, expected write list) and compares the
// observed RAM writes and status outputs against it.
module tb_matrix_loader;

    logic        clock;
    logic        reset_l;
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        a_wr_en;
    logic [11:0] a_wr_addr;
    logic [7:0]  a_wr_data;
    logic        b_wr_en;
    logic [5:0]  b_wr_addr;
    logic [7:0]  b_wr_data;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic [15:0] loadTicks;

    matrix_loader dut (
        .clock     (clock),
        .reset_l   (reset_l),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_wr_en   (a_wr_en),
        .a_wr_addr (a_wr_addr),
        .a_wr_data (a_wr_data),
        .b_wr_en   (b_wr_en),
        .b_wr_addr (b_wr_addr),
        .b_wr_data (b_wr_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .loadTicks (loadTicks)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed writes: {is_b, addr(12), data(8)}
    logic [20:0] obs_q[$];
    int          both_cnt    = 0;
    int          last_b_cnt  = 0;
    logic        done_at_last = 1'b0;

    always @(negedge clock) begin
        if (a_wr_en && b_wr_en) both_cnt++;
        if (a_wr_en) obs_q.push_back({1'b0, a_wr_addr, a_wr_data});
        if (b_wr_en) begin
            obs_q.push_back({1'b1, 6'd0, b_wr_addr, b_wr_data});
            if (b_wr_addr == 6'd63) begin
                done_at_last = done;
                last_b_cnt++;
            end
        end
    end

    // Reference model: 0 idle, 1 loading A, 2 loading B, 3 done
    int          ph = 0;
    int          cnt = 0;
    logic [15:0] m_sum = '0;
    logic [15:0] m_ticks = '0;
    logic [20:0] exp_q[$];
    int          base = 0;

    task automatic drive(input logic s, input logic ab, input logic v, input logic [7:0] d);
        @(negedge clock);
        start = s; abort = ab; in_valid = v; in_data = d;
        @(posedge clock);
        if (ph == 0 || ph == 3) begin
            if (s && !ab) begin
                ph = 1; cnt = 0; m_sum = '0; m_ticks = '0;
            end
        end else begin
            if (m_ticks != 16'hFFFF) m_ticks = m_ticks + 16'd1;
            if (ab) begin
                ph = 0;
            end else if (v) begin
                exp_q.push_back({ph == 2, 12'(cnt), d});
                m_sum = m_sum + 16'(d);
                cnt++;
                if (ph == 1 && cnt == 4096) begin
                    ph = 2; cnt = 0;
                end else if (ph == 2 && cnt == 64) begin
                    ph = 3;
                end
            end
        end
    endtask

    // mode 0: no stalls, mode 1: valid alternates 1,0,..., mode 2: random stalls/data.
    // Non-random data is the byte index within its matrix, mod 256.
    task automatic load_bytes(input int mode, output logic timed_out);
        int   k = 0;
        int   c = 0;
        logic v;
        logic [7:0] d;
        while (ph != 3 && c < 20000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (!v)            d = 8'($urandom);
            else if (mode == 2) d = 8'($urandom);
            else               d = 8'(k % 256);
            drive(1'b0, 1'b0, v, d);
            if (v) k = (k + 1) % 4096;
            c++;
        end
        timed_out = (ph != 3);
    endtask

    function automatic int count_bad(input int b);
        int bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b + i >= obs_q.size()) bad++;
            else if (obs_q[b + i] !== exp_q[i]) bad++;
        end
        return bad;
    endfunction

    task automatic new_scenario();
        exp_q.delete();
        base = obs_q.size();
    endtask

    task automatic test_reset();
        reset_l = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        #2;
        n_checks++;
        if ({in_ready, a_wr_en, a_wr_addr, a_wr_data, b_wr_en, b_wr_addr, b_wr_data,
             busy, done, checksum, loadTicks} !== '0)
            $display("FAIL reset_outputs: got ready=%b busy=%b done=%b sum=%h ticks=%h, want all 0",
                     in_ready, busy, done, checksum, loadTicks);
        else n_pass++;
        @(negedge clock);
        reset_l = 1'b1;
        ph = 0;
    endtask

    task automatic test_full_load();
        logic to;
        int   b0, l0;
        new_scenario();
        b0 = both_cnt; l0 = last_b_cnt;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL start_ready: got ready=%b busy=%b, want 1 1", in_ready, busy);
        else n_pass++;
        load_bytes(0, to);
        n_checks++;
        if (to) $display("FAIL full_timeout: got no done within bound, want done");
        else n_pass++;
        #1;
        n_checks++;
        if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL full_status: got done=%b ready=%b busy=%b, want 1 0 0",
                     done, in_ready, busy);
        else n_pass++;
        n_checks++;
        if (checksum !== 16'hFFE0) $display("FAIL full_checksum: got %h, want ffe0", checksum);
        else n_pass++;
        n_checks++;
        if (loadTicks !== 16'h1040) $display("FAIL full_ticks: got %h, want 1040", loadTicks);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (obs_q.size() - base != 4160 || count_bad(base) != 0)
            $display("FAIL full_writes: got %0d writes %0d wrong, want 4160 0",
                     obs_q.size() - base, count_bad(base));
        else n_pass++;
        n_checks++;
        if (obs_q[base + 4095] !== {1'b0, 12'd4095, 8'hFF} ||
            obs_q[base + 4096] !== {1'b1, 12'd0, 8'h00})
            $display("FAIL a_to_b_boundary: got %h %h, want 0fffff 100000",
                     obs_q[base + 4095], obs_q[base + 4096]);
        else n_pass++;
        n_checks++;
        if (both_cnt != b0) $display("FAIL a_b_overlap: got %0d, want 0", both_cnt - b0);
        else n_pass++;
        n_checks++;
        if (last_b_cnt != l0 + 1 || done_at_last !== 1'b1)
            $display("FAIL done_with_last_b: got cnt=%0d done=%b, want 1 1",
                     last_b_cnt - l0, done_at_last);
        else n_pass++;
        // Stream and abort in DONE must be ignored
        repeat (4) drive(1'b0, 1'b0, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        #1;
        n_checks++;
        if (done !== 1'b1 || checksum !== 16'hFFE0 || obs_q.size() - base != 4160)
            $display("FAIL done_ignores: got done=%b sum=%h writes=%0d, want 1 ffe0 4160",
                     done, checksum, obs_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_stalled_load();
        logic to;
        new_scenario();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        n_checks++;
        if (checksum !== 16'h0000 || loadTicks !== 16'h0000 || done !== 1'b0)
            $display("FAIL restart_clear: got sum=%h ticks=%h done=%b, want 0 0 0",
                     checksum, loadTicks, done);
        else n_pass++;
        load_bytes(1, to);
        #1;
        n_checks++;
        if (to || checksum !== 16'hFFE0 || loadTicks !== 16'h207F || done !== 1'b1)
            $display("FAIL stalled_status: got sum=%h ticks=%h done=%b, want ffe0 207f 1",
                     checksum, loadTicks, done);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (obs_q.size() - base != 4160 || count_bad(base) != 0)
            $display("FAIL stalled_writes: got %0d writes %0d wrong, want 4160 0",
                     obs_q.size() - base, count_bad(base));
        else n_pass++;
    endtask

    task automatic test_abort();
        new_scenario();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (100) drive(1'b0, 1'b0, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 1'b1, 8'h01);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || checksum !== 16'd100)
            $display("FAIL abort_state: got ready=%b busy=%b done=%b sum=%0d, want 0 0 0 100",
                     in_ready, busy, done, checksum);
        else n_pass++;
        n_checks++;
        if (loadTicks !== 16'd101) $display("FAIL abort_ticks: got %0d, want 101", loadTicks);
        else n_pass++;
        repeat (4) drive(1'b0, 1'b0, 1'b1, 8'hFF);
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || checksum !== 16'd100)
            $display("FAIL start_abort_idle: got busy=%b ready=%b sum=%0d, want 0 0 100",
                     busy, in_ready, checksum);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (obs_q.size() - base != 100 || count_bad(base) != 0)
            $display("FAIL abort_writes: got %0d writes %0d wrong, want 100 0",
                     obs_q.size() - base, count_bad(base));
        else n_pass++;
        new_scenario();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        n_checks++;
        if (checksum !== 16'h0000 || busy !== 1'b1)
            $display("FAIL abort_restart: got sum=%h busy=%b, want 0 1", checksum, busy);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1, 8'h55);
        #1;
        n_checks++;
        if (a_wr_en !== 1'b1 || a_wr_addr !== 12'd0 || a_wr_data !== 8'h55)
            $display("FAIL restart_addr0: got en=%b addr=%0d data=%h, want 1 0 55",
                     a_wr_en, a_wr_addr, a_wr_data);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b1, 8'h66);
        #1;
        n_checks++;
        if (a_wr_addr !== 12'd1 || a_wr_data !== 8'h66 || checksum !== 16'h00BB)
            $display("FAIL start_while_busy: got addr=%0d data=%h sum=%h, want 1 66 00bb",
                     a_wr_addr, a_wr_data, checksum);
        else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (obs_q.size() - base != 2 || count_bad(base) != 0)
            $display("FAIL restart_writes: got %0d writes %0d wrong, want 2 0",
                     obs_q.size() - base, count_bad(base));
        else n_pass++;
    endtask

    task automatic test_random_load();
        logic to;
        new_scenario();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        load_bytes(2, to);
        #1;
        n_checks++;
        if (to || done !== 1'b1) $display("FAIL random_done: got done=%b, want 1", done);
        else n_pass++;
        n_checks++;
        if (checksum !== m_sum || loadTicks !== m_ticks)
            $display("FAIL random_sums: got sum=%h ticks=%h, want %h %h",
                     checksum, loadTicks, m_sum, m_ticks);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (obs_q.size() - base != exp_q.size() || count_bad(base) != 0)
            $display("FAIL random_writes: got %0d writes %0d wrong, want %0d 0",
                     obs_q.size() - base, count_bad(base), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        logic to;
        new_scenario();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2000; i++) drive(1'b0, 1'b0, 1'b1, 8'(i % 256));
        #1;
        n_checks++;
        if (a_wr_en !== 1'b1 || a_wr_addr !== 12'd1999)
            $display("FAIL pre_reset_write: got en=%b addr=%0d, want 1 1999", a_wr_en, a_wr_addr);
        else n_pass++;
        reset_l = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, a_wr_en, a_wr_addr, a_wr_data, b_wr_en, b_wr_addr, b_wr_data,
             busy, done, checksum, loadTicks} !== '0)
            $display("FAIL mid_reset_outputs: got en=%b ready=%b busy=%b sum=%h ticks=%h, want 0",
                     a_wr_en, in_ready, busy, checksum, loadTicks);
        else n_pass++;
        ph = 0;
        @(negedge clock);
        reset_l = 1'b1;
        new_scenario();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        load_bytes(0, to);
        #1;
        n_checks++;
        if (to || checksum !== 16'hFFE0 || done !== 1'b1)
            $display("FAIL reload_after_reset: got sum=%h done=%b, want ffe0 1", checksum, done);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (obs_q.size() - base != 4160 || count_bad(base) != 0)
            $display("FAIL reload_writes: got %0d writes %0d wrong, want 4160 0",
                     obs_q.size() - base, count_bad(base));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_stalled_load();
        test_abort();
        test_random_load();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
